// File: rtl/signed_serial_subtractor.sv
// Bit-serial signed subtractor: exact SIZE+1-bit a - b, one bit per clock, LSB first.
// Optional add/subtract select via macro SIGNED_SERIAL_SUB_ADD_MODE_EN (adds port op).
module signed_serial_subtractor #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
`ifdef SIGNED_SERIAL_SUB_ADD_MODE_EN
  input  logic            op,
`endif
  output logic            busy,
  output logic            done,
  output logic [SIZE:0]   result,
  output logic            overflow
);

  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [SIZE:0]     a_sr_q, b_sr_q;
  logic [SIZE-1:0]   res_sr_q;
  logic              carry_q;
  logic              busy_q, done_q, ovf_q;
  logic [SIZE:0]     result_q;
  logic              add_q;

  logic              start_add;
  logic              b_bit, sum_d, carry_d;

`ifdef SIGNED_SERIAL_SUB_ADD_MODE_EN
  assign start_add = op;
`else
  assign start_add = 1'b0;
`endif

  // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
  always_comb begin
    b_bit   = add_q ? b_sr_q[0] : ~b_sr_q[0];
    sum_d   = a_sr_q[0] ^ b_bit ^ carry_q;
    carry_d = (a_sr_q[0] & b_bit) | (a_sr_q[0] & carry_q) | (b_bit & carry_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      add_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          res_sr_q <= {sum_d, res_sr_q[SIZE-1:1]};
          carry_q  <= carry_d;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(SIZE)) begin
            // res_sr_q already holds bits SIZE-1..0; sum_d is the sign bit.
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= {sum_d, res_sr_q};
            ovf_q    <= sum_d ^ res_sr_q[SIZE-1];
          end
        end
        default: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            a_sr_q  <= {a[SIZE-1], a};
            b_sr_q  <= {b[SIZE-1], b};
            carry_q <= ~start_add;
            add_q   <= start_add;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_signed_serial_subtractor.sv
// Directed self-checking bench for signed_serial_subtractor (SIZE=8).
module tb_signed_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset, start, op;
  logic [7:0] a, b;
  logic       busy, done, overflow;
  logic [8:0] result;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  signed_serial_subtractor #(.SIZE(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
`ifdef SIGNED_SERIAL_SUB_ADD_MODE_EN
    .op(op),
`endif
    .busy(busy), .done(done), .result(result), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // done must never coincide with busy
  always @(negedge clk) chk("done_busy", {31'd0, done & busy}, 32'd0);

  // One operation; while busy, scramble a/b/op and pulse start to prove they are ignored.
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic top, input logic [8:0] er, input logic eov);
    int cyc;
    @(negedge clk);
    a = ta; b = tb_; op = top; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 30) begin
      cyc++;
      start = (cyc == 3);
      a = 8'($urandom); b = 8'($urandom); op = ~op;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, cyc, 9);
    chk({tag, "_done"}, {31'd0, done}, 1);
    chk({tag, "_result"}, {23'd0, result}, {23'd0, er});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eov});
    @(negedge clk);
    chk({tag, "_done_low"}, {31'd0, done}, 0);
    chk({tag, "_hold"}, {23'd0, result}, {23'd0, er});
  endtask

  logic [7:0] ba [3] = '{8'd10, 8'd100, 8'h9C};
  logic [7:0] bb [3] = '{8'd20, 8'h9C, 8'd100};
  logic [8:0] br [3] = '{9'h1F6, 9'h0C8, 9'h138};
  logic       bo [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    int cyc, pulses;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; op = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_result", {23'd0, result}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    reset = 1'b0;

    do_op("5m3",     8'd5,   8'd3,   1'b0, 9'h002, 1'b0);
    do_op("m128m1",  8'h80,  8'd1,   1'b0, 9'h17F, 1'b1);
    do_op("127mm128",8'd127, 8'h80,  1'b0, 9'h0FF, 1'b1);
    do_op("m5mm5",   8'hFB,  8'hFB,  1'b0, 9'h000, 1'b0);
    do_op("m1m1",    8'hFF,  8'd1,   1'b0, 9'h1FE, 1'b0);
    do_op("0mm128",  8'd0,   8'h80,  1'b0, 9'h080, 1'b1);

    // Back-to-back: start held high, next operands presented in the DONE cycle.
    @(negedge clk);
    a = ba[0]; b = bb[0]; op = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cyc = 0;
      while (!done && cyc < 30) begin
        cyc++;
        a = 8'($urandom); b = 8'($urandom);
        @(negedge clk);
      end
      chk("b2b_latency", cyc, 9);
      chk("b2b_result", {23'd0, result}, {23'd0, br[k]});
      chk("b2b_ovf", {31'd0, overflow}, {31'd0, bo[k]});
      if (k < 2) begin a = ba[k+1]; b = bb[k+1]; end
      else start = 1'b0;
      @(negedge clk);
    end
    chk("b2b_idle", {31'd0, busy}, 0);

    // Abort mid-operation with reset.
    @(negedge clk);
    a = 8'd50; b = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_result", {23'd0, result}, 0);
    chk("abort_ovf", {31'd0, overflow}, 0);
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    do_op("after_abort", 8'd50, 8'd7, 1'b0, 9'h02B, 1'b0);

`ifdef SIGNED_SERIAL_SUB_ADD_MODE_EN
    do_op("add_100p50", 8'd100, 8'd50, 1'b1, 9'h096, 1'b1);
    do_op("sub_100m50", 8'd100, 8'd50, 1'b0, 9'h032, 1'b0);
    do_op("add_m1pm1",  8'hFF,  8'hFF, 1'b1, 9'h1FE, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
